// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the branch-predictor update controller.
//   bp_state_t  : sequencer states (INIT sweep, IDLE, READ, WRITE)
//   pht_ctr_t   : 2-bit saturating PHT counter
//   bp_update_t : queued update record at the default geometry
//   sat_next()  : saturating counter step toward the resolved direction
//   BP_INIT_CTR : default counter value written by the init sweep
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int H_WIDTH_DEF   = 2;
    localparam int IDX_WIDTH_DEF = 6;

    typedef logic [1:0] pht_ctr_t;

    // Weakly taken.
    localparam pht_ctr_t BP_INIT_CTR = 2'b10;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        READ,
        WRITE
    } bp_state_t;

    typedef struct packed {
        logic [H_WIDTH_DEF-1:0]   hist;
        logic [IDX_WIDTH_DEF-1:0] idx;
        logic                     taken;
    } bp_update_t;

    function automatic pht_ctr_t sat_next(input pht_ctr_t ctr, input logic taken);
        pht_ctr_t result;
        if (taken) begin
            result = (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end else begin
            result = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// bp_update_ctrl_if
// Resolution handshake from EX plus the PHT access port of the update
// controller.
//   master : EX stage / PHT storage side (drives res_*, pht_rdata)
//   slave  : bp_update_ctrl (drives res_ready, pht_raddr, pht_we,
//            pht_waddr, pht_wdata)
// ---------------------------------------------------------------------------
interface bp_update_ctrl_if #(
    parameter int H_WIDTH   = 2,
    parameter int IDX_WIDTH = 6
);
    logic                         res_valid;
    logic [31:0]                  res_pc;
    logic [H_WIDTH-1:0]           res_hist;
    logic                         res_taken;
    logic                         res_mispredict;
    logic                         res_ready;

    logic [H_WIDTH+IDX_WIDTH-1:0] pht_raddr;
    logic [1:0]                   pht_rdata;
    logic                         pht_we;
    logic [H_WIDTH+IDX_WIDTH-1:0] pht_waddr;
    logic [1:0]                   pht_wdata;

    modport master (
        output res_valid, res_pc, res_hist, res_taken, res_mispredict,
        input  res_ready,
        input  pht_raddr, pht_we, pht_waddr, pht_wdata,
        output pht_rdata
    );

    modport slave (
        input  res_valid, res_pc, res_hist, res_taken, res_mispredict,
        output res_ready,
        output pht_raddr, pht_we, pht_waddr, pht_wdata,
        input  pht_rdata
    );

endinterface

// File: rtl/bp_update_fifo.sv
// ---------------------------------------------------------------------------
// bp_update_fifo
// Small in-order queue of resolved-branch updates.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : enqueue din (caller guarantees !full)
//   pop      : drop the head entry (caller guarantees !empty)
//   head     : oldest entry, valid while !empty
//   full, empty, count : occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module bp_update_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         din,
    input  logic                     pop,
    output T                         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    T     mem [DEPTH];
    ptr_t wr_ptr;
    ptr_t rd_ptr;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever read after
    // being written, and leaving it reset-free lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == cnt_t'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// bp_update_ctrl
// Owns the PHT write side and the speculative global history register.
// After reset it sweeps the PHT writing INIT_CTR to every entry, then drains
// queued EX resolutions as read-modify-write saturating-counter updates
// (one update per two cycles, in arrival order).
//
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   load_stall       : IF stalled, freezes speculative GHR shifting
//   pred_valid/taken : prediction issued by IF this cycle
//   ghr              : speculative history to the predictor
//   bus (slave)      : res_* resolution handshake, res_ready, PHT port
//                      (pht_raddr/pht_rdata combinational read, pht_we/
//                      pht_waddr/pht_wdata write)
//   init_busy        : init sweep in progress
//   stat_updates/stat_mispredicts/stat_drops : event counters
//
// Build option: define BP_STATS_EN to build the statistic counters; when it
// is undefined the three stat ports are tied to zero.
// ---------------------------------------------------------------------------
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int       H_WIDTH   = 2,
    parameter int       IDX_WIDTH = 6,
    parameter int       DEPTH     = 4,
    parameter pht_ctr_t INIT_CTR  = BP_INIT_CTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_stall,
    input  logic               pred_valid,
    input  logic               pred_taken,
    output logic [H_WIDTH-1:0] ghr,
    bp_update_ctrl_if.slave    bus,
    output logic               init_busy,
    output logic [31:0]        stat_updates,
    output logic [31:0]        stat_mispredicts,
    output logic [31:0]        stat_drops
);
    localparam int A_W   = H_WIDTH + IDX_WIDTH;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef logic [A_W-1:0] addr_t;

    typedef struct packed {
        logic [H_WIDTH-1:0]   hist;
        logic [IDX_WIDTH-1:0] idx;
        logic                 taken;
    } update_t;

    bp_state_t        state;
    bp_state_t        state_next;
    addr_t            init_cnt;
    pht_ctr_t         ctr;

    update_t          push_data;
    update_t          head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             res_ready;

    logic             we;
    addr_t            waddr;
    pht_ctr_t         wdata;
    addr_t            raddr;
    addr_t            head_addr;

    // Only the index bits of the PC address the PHT.
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{bus.res_pc[31:IDX_WIDTH+2], bus.res_pc[1:0]};

    // ---------------- update queue ----------------
    assign init_busy = (state == INIT);
    assign res_ready = !full && !init_busy;
    assign push      = bus.res_valid && res_ready;
    assign push_data = '{hist: bus.res_hist, idx: bus.res_pc[IDX_WIDTH+1:2], taken: bus.res_taken};
    assign head_addr = {head.hist, head.idx};

    bp_update_fifo #(
        .DEPTH (DEPTH),
        .T     (update_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
            ctr      <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) init_cnt <= init_cnt + addr_t'(1);
            if (state == READ) ctr <= bus.pht_rdata;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        raddr      = '0;
        pop        = 1'b0;
        case (state)
            INIT: begin
                we    = 1'b1;
                waddr = init_cnt;
                wdata = INIT_CTR;
                if (init_cnt == '1) state_next = IDLE;
            end
            IDLE: begin
                if (!empty) state_next = READ;
            end
            READ: begin
                raddr      = head_addr;
                state_next = WRITE;
            end
            WRITE: begin
                we    = 1'b1;
                waddr = head_addr;
                wdata = sat_next(ctr, head.taken);
                pop   = 1'b1;
                // An entry pushed this same cycle also keeps the pipe busy.
                state_next = (count > CNT_W'(1) || push) ? READ : IDLE;
            end
            default: state_next = INIT;
        endcase
    end

    // The state register sits in INIT while rst is high, so the write enable
    // is masked to keep the PHT untouched during reset.
    assign bus.pht_we    = we && !rst;
    assign bus.pht_waddr = waddr;
    assign bus.pht_wdata = wdata;
    assign bus.pht_raddr = raddr;
    assign bus.res_ready = res_ready;

    // ---------------- speculative GHR ----------------
    logic [H_WIDTH-1:0] ghr_repair;
    logic [H_WIDTH-1:0] ghr_shift;

    generate
        if (H_WIDTH == 1) begin : g_ghr_1
            assign ghr_repair = bus.res_taken;
            assign ghr_shift  = pred_taken;
        end else begin : g_ghr_n
            assign ghr_repair = {bus.res_hist[H_WIDTH-2:0], bus.res_taken};
            assign ghr_shift  = {ghr[H_WIDTH-2:0], pred_taken};
        end
    endgenerate

    // Repair wins over a same-cycle prediction: that prediction is wrong-path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (bus.res_valid && bus.res_mispredict) begin
            ghr <= ghr_repair;
        end else if (pred_valid && !load_stall) begin
            ghr <= ghr_shift;
        end
    end

    // ---------------- statistics ----------------
`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
            stat_drops       <= '0;
        end else begin
            if (pop) stat_updates <= stat_updates + 32'd1;
            if (bus.res_valid && bus.res_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
            if (bus.res_valid && !res_ready && !init_busy) stat_drops <= stat_drops + 32'd1;
        end
    end
`else
    assign stat_updates     = '0;
    assign stat_mispredicts = '0;
    assign stat_drops       = '0;
`endif

endmodule
